// File: rtl/cpu_pkg.sv
// Shared definitions for the NES CPU core: status-register bit positions,
// set/clear opcode encodings, branch selector fields and the reset value of P.
// Latency: n/a (package). Backpressure: n/a.
package cpu_pkg;

  // Bit positions inside P = {N,V,1,B,D,I,Z,C}
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // P after reset: I=1 and the unused bit 5 set
  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

  // Explicit flag set/clear instructions
  typedef enum logic [2:0] {
    SC_NONE = 3'd0,
    SC_CLC  = 3'd1,
    SC_SEC  = 3'd2,
    SC_CLI  = 3'd3,
    SC_SEI  = 3'd4,
    SC_CLV  = 3'd5,
    SC_CLD  = 3'd6,
    SC_SED  = 3'd7
  } sc_op_e;

  // BR_cond is opcode[7:5]: [2:1] picks the flag, [0] is the value that takes the branch
  localparam int BR_SEL_MSB = 2;
  localparam int BR_SEL_LSB = 1;
  localparam int BR_VAL_BIT = 0;

  typedef enum logic [1:0] {
    BR_FLAG_N = 2'b00,
    BR_FLAG_V = 2'b01,
    BR_FLAG_C = 2'b10,
    BR_FLAG_Z = 2'b11
  } br_flag_e;

endpackage

// File: rtl/branch_cond.sv
// Purpose: decides whether a 6502 conditional branch is taken from BR_cond and P.
// Latency: combinational. Backpressure: none.
// Ports: br_cond_i (opcode[7:5]), p_i (status register), br_take_o (taken).
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] br_cond_i,
  input  logic [7:0] p_i,
  output logic       br_take_o
);

  logic sel_flag;
  br_flag_e sel;

  // Only N, V, Z and C can be branched on
  logic unused_p;
  assign unused_p = ^{p_i[P_U], p_i[P_B], p_i[P_D], p_i[P_I]};

  assign sel = br_flag_e'(br_cond_i[BR_SEL_MSB:BR_SEL_LSB]);

  always_comb begin
    sel_flag = 1'b0;
    case (sel)
      BR_FLAG_N: sel_flag = p_i[P_N];
      BR_FLAG_V: sel_flag = p_i[P_V];
      BR_FLAG_C: sel_flag = p_i[P_C];
      BR_FLAG_Z: sel_flag = p_i[P_Z];
      default:   sel_flag = 1'b0;
    endcase
    br_take_o = (sel_flag == br_cond_i[BR_VAL_BIT]);
  end

endmodule

// File: rtl/status_flag_unit.sv
// Purpose: 6502 status register P with ALU commit, bus load, set/clear, BIT,
//   interrupt I-set, push image, branch evaluation and the delayed I mask.
// Latency: flag writes visible on P_q one cycle after the enabling edge; P_push/BR_take combinational.
// Backpressure: none; STEP_en=0 freezes every register.
// Ports: CLK/RST_n (sync active-low), STEP_en, SYNC, ALU {RES,Cout,OVFout},
//   enables {NZ_en,C_en,V_en,BIT_en,PLD_en,RTI_en,INT_SEI}, SC_op, DB, BRK_flag,
//   BR_cond -> P_q, P_push, BR_take, I_mask.
module status_flag_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       STEP_en,
  input  logic       SYNC,
  input  logic [7:0] RES,
  input  logic       Cout,
  input  logic       OVFout,
  input  logic       NZ_en,
  input  logic       C_en,
  input  logic       V_en,
  input  logic       BIT_en,
  input  logic [7:0] DB,
  input  logic       PLD_en,
  input  logic       RTI_en,
  input  logic [2:0] SC_op,
  input  logic       INT_SEI,
  input  logic       BRK_flag,
  input  logic [2:0] BR_cond,
  output logic [7:0] P_q,
  output logic [7:0] P_push,
  output logic       BR_take,
  output logic       I_mask
);

  sc_op_e     sc;
  logic       res_zero;
  logic       n_d, v_d, d_d, i_d, z_d, c_d;
  logic [7:0] p_d;
  logic       i_mask_q, i_mask_d;

  // Bits 5 and 4 of a pulled P are not stored
  logic unused_db;
  assign unused_db = ^DB[5:4];

  assign sc       = sc_op_e'(SC_op);
  assign res_zero = (RES == 8'h00);

  // Per-flag priority: PLD > INT_SEI > set/clear > BIT > ALU. Each flag only
  // lists the sources that can write it, so lower sources still reach flags
  // that a higher source leaves alone.
  always_comb begin
    n_d = PLD_en ? DB[P_N] :
          BIT_en ? DB[7]   :
          NZ_en  ? RES[7]  : P_q[P_N];

    v_d = PLD_en        ? DB[P_V] :
          (sc == SC_CLV) ? 1'b0   :
          BIT_en        ? DB[6]   :
          V_en          ? OVFout  : P_q[P_V];

    z_d = PLD_en            ? DB[P_Z]  :
          (BIT_en || NZ_en) ? res_zero : P_q[P_Z];

    c_d = PLD_en         ? DB[P_C] :
          (sc == SC_CLC) ? 1'b0    :
          (sc == SC_SEC) ? 1'b1    :
          C_en           ? Cout    : P_q[P_C];

    i_d = PLD_en         ? DB[P_I] :
          INT_SEI        ? 1'b1    :
          (sc == SC_CLI) ? 1'b0    :
          (sc == SC_SEI) ? 1'b1    : P_q[P_I];

    d_d = PLD_en         ? DB[P_D] :
          (sc == SC_CLD) ? 1'b0    :
          (sc == SC_SED) ? 1'b1    : P_q[P_D];

    p_d = {n_d, v_d, 1'b1, 1'b0, d_d, i_d, z_d, c_d};
  end

  // The poller sees I from before this edge's update, giving the one-instruction
  // delay after CLI/SEI/PLP; RTI and interrupt entry bypass that delay.
  always_comb begin
    i_mask_d = i_mask_q;
    if (PLD_en && RTI_en) begin
      i_mask_d = DB[P_I];
    end else if (INT_SEI) begin
      i_mask_d = 1'b1;
    end else if (SYNC) begin
      i_mask_d = P_q[P_I];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      P_q      <= RESET_P;
      i_mask_q <= 1'b1;
    end else if (STEP_en) begin
      P_q      <= p_d;
      i_mask_q <= i_mask_d;
    end
  end

  assign I_mask = i_mask_q;
  assign P_push = {P_q[P_N], P_q[P_V], 1'b1, BRK_flag, P_q[P_D], P_q[P_I], P_q[P_Z], P_q[P_C]};

  branch_cond u_branch_cond (
    .br_cond_i (BR_cond),
    .p_i       (P_q),
    .br_take_o (BR_take)
  );

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;

  logic       CLK = 1'b0;
  logic       RST_n, STEP_en, SYNC;
  logic [7:0] RES;
  logic       Cout, OVFout, NZ_en, C_en, V_en, BIT_en;
  logic [7:0] DB;
  logic       PLD_en, RTI_en;
  logic [2:0] SC_op;
  logic       INT_SEI, BRK_flag;
  logic [2:0] BR_cond;
  logic [7:0] P_q, P_push;
  logic       BR_take, I_mask;

  status_flag_unit dut (
    .CLK(CLK), .RST_n(RST_n), .STEP_en(STEP_en), .SYNC(SYNC),
    .RES(RES), .Cout(Cout), .OVFout(OVFout),
    .NZ_en(NZ_en), .C_en(C_en), .V_en(V_en), .BIT_en(BIT_en),
    .DB(DB), .PLD_en(PLD_en), .RTI_en(RTI_en), .SC_op(SC_op),
    .INT_SEI(INT_SEI), .BRK_flag(BRK_flag), .BR_cond(BR_cond),
    .P_q(P_q), .P_push(P_push), .BR_take(BR_take), .I_mask(I_mask)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] p;
    logic       im;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] mp;
  logic       mi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Branch truth table written out per opcode
  function automatic logic br_exp(input logic [2:0] c, input logic [7:0] p);
    case (c)
      3'd0: return !p[7];  // BPL
      3'd1: return  p[7];  // BMI
      3'd2: return !p[6];  // BVC
      3'd3: return  p[6];  // BVS
      3'd4: return !p[0];  // BCC
      3'd5: return  p[0];  // BCS
      3'd6: return !p[1];  // BNE
      default: return p[1]; // BEQ
    endcase
  endfunction

  // Reference model: apply sources lowest priority first so higher ones overwrite
  task automatic model_step();
    logic [7:0] np;
    logic       ni;
    if (!RST_n) begin
      mp = 8'h24;
      mi = 1'b1;
    end else if (STEP_en) begin
      np = mp;
      ni = mi;
      if (NZ_en) begin np[7] = RES[7]; np[1] = (RES == 8'h00); end
      if (C_en) np[0] = Cout;
      if (V_en) np[6] = OVFout;
      if (BIT_en) begin np[7] = DB[7]; np[6] = DB[6]; np[1] = (RES == 8'h00); end
      case (SC_op)
        3'd1: np[0] = 1'b0;
        3'd2: np[0] = 1'b1;
        3'd3: np[2] = 1'b0;
        3'd4: np[2] = 1'b1;
        3'd5: np[6] = 1'b0;
        3'd6: np[3] = 1'b0;
        3'd7: np[3] = 1'b1;
        default: ;
      endcase
      if (INT_SEI) np[2] = 1'b1;
      if (PLD_en) np = DB;
      np[5] = 1'b1;
      np[4] = 1'b0;
      if (SYNC) ni = mp[2];
      if (INT_SEI) ni = 1'b1;
      if (PLD_en && RTI_en) ni = DB[2];
      mp = np;
      mi = ni;
    end
  endtask

  // Push the expected result for the inputs now driven, clock, then pop and compare
  task automatic tick(input string tag);
    exp_t e;
    model_step();
    e.p  = mp;
    e.im = mi;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({tag, "_p"}, P_q, e.p);
    check({tag, "_im"}, I_mask, e.im);
    check({tag, "_push"}, P_push, {e.p[7:6], 1'b1, BRK_flag, e.p[3:0]});
    check({tag, "_br"}, BR_take, br_exp(BR_cond, e.p));
  endtask

  task automatic idle();
    RST_n = 1'b1; STEP_en = 1'b1; SYNC = 1'b0;
    RES = 8'h00; Cout = 1'b0; OVFout = 1'b0;
    NZ_en = 1'b0; C_en = 1'b0; V_en = 1'b0; BIT_en = 1'b0;
    DB = 8'h00; PLD_en = 1'b0; RTI_en = 1'b0; SC_op = 3'd0;
    INT_SEI = 1'b0; BRK_flag = 1'b0; BR_cond = 3'd0;
  endtask

  initial begin
    idle();
    // Reset while stalled
    RST_n = 1'b0; STEP_en = 1'b0; BRK_flag = 1'b1;
    tick("rst");
    check("rst_p_const", P_q, 8'h24);
    check("rst_im_const", I_mask, 1'b1);
    check("rst_push_const", P_push, 8'h34);

    // ALU commit
    idle(); RES = 8'h00; Cout = 1'b1; OVFout = 1'b1; NZ_en = 1'b1; C_en = 1'b1; V_en = 1'b1;
    tick("alu0");
    check("alu0_const", P_q, 8'h67);
    idle(); RES = 8'h80; NZ_en = 1'b1;
    tick("alu1");
    check("alu1_const", P_q, 8'hE5);

    // CLI takes effect on the mask only at the next instruction boundary
    idle(); SC_op = 3'd3;
    tick("cli");
    check("cli_p_const", P_q, 8'hE1);
    check("cli_im_const", I_mask, 1'b1);
    idle();
    tick("cli_nosync");
    check("cli_nosync_im_const", I_mask, 1'b1);
    idle(); SYNC = 1'b1;
    tick("cli_sync");
    check("cli_sync_im_const", I_mask, 1'b0);

    // PLP: mask follows one boundary later
    idle(); DB = 8'hFF; PLD_en = 1'b1;
    tick("plp");
    check("plp_p_const", P_q, 8'hEF);
    check("plp_im_const", I_mask, 1'b0);
    idle(); SYNC = 1'b1;
    tick("plp_sync");
    check("plp_sync_im_const", I_mask, 1'b1);

    // RTI: mask loads on the same edge
    idle(); SC_op = 3'd3; tick("rti_cli");
    idle(); SYNC = 1'b1; tick("rti_sync");
    idle(); DB = 8'hFF; PLD_en = 1'b1; RTI_en = 1'b1;
    tick("rti");
    check("rti_im_const", I_mask, 1'b1);

    // Priority: load beats set/clear and ALU
    idle(); DB = 8'h00; PLD_en = 1'b1; SC_op = 3'd2; NZ_en = 1'b1; RES = 8'h80;
    tick("prio");
    check("prio_const", P_q, 8'h20);

    // Lower sources still reach untouched flags
    idle(); SC_op = 3'd2; NZ_en = 1'b1; RES = 8'h00; V_en = 1'b1; OVFout = 1'b1;
    tick("sec_nz");

    // Stall holds everything even with SYNC
    idle(); STEP_en = 1'b0; SYNC = 1'b1; SC_op = 3'd5; PLD_en = 1'b1; DB = 8'h0C;
    tick("stall");
    check("stall_im_const", I_mask, 1'b1);

    // Reset mid-instruction discards the pending load
    idle(); RST_n = 1'b0; PLD_en = 1'b1; DB = 8'hC3; RTI_en = 1'b1;
    tick("rst_mid");
    check("rst_mid_const", P_q, 8'h24);

    // Interrupt entry beats CLI and sets the mask immediately
    idle(); SC_op = 3'd3; tick("int_cli");
    idle(); SYNC = 1'b1; tick("int_sync");
    idle(); INT_SEI = 1'b1; SC_op = 3'd3;
    tick("int");
    check("int_im_const", I_mask, 1'b1);
    idle(); INT_SEI = 1'b1; SC_op = 3'd7; tick("int_sed");

    // BIT with ALU enables competing
    idle(); BIT_en = 1'b1; DB = 8'hC0; RES = 8'h00; V_en = 1'b1; OVFout = 1'b0; NZ_en = 1'b1;
    tick("bit0");
    idle(); BIT_en = 1'b1; DB = 8'h3F; RES = 8'h01; SC_op = 3'd5;
    tick("bit1");

    // Branch: explicit BCS/BCC case, then every selector against every N/V/Z/C pattern
    idle(); DB = 8'h01; PLD_en = 1'b1; tick("br_ld");
    idle(); BR_cond = 3'b101; #1;
    check("bcs_const", BR_take, 1'b1);
    BR_cond = 3'b100; #1;
    check("bcc_const", BR_take, 1'b0);
    for (int v = 0; v < 16; v++) begin
      idle(); PLD_en = 1'b1;
      DB = {v[3], v[2], 4'b0000, v[1], v[0]};
      tick("br_load");
      idle();
      for (int c = 0; c < 8; c++) begin
        BR_cond = c[2:0]; #1;
        check("br_sweep", BR_take, br_exp(BR_cond, mp));
      end
    end

    // Random mix
    for (int k = 0; k < 600; k++) begin
      RST_n    = ($urandom_range(0, 59) != 0);
      STEP_en  = ($urandom_range(0, 4) != 0);
      SYNC     = $urandom_range(0, 1);
      RES      = (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      Cout     = $urandom_range(0, 1);
      OVFout   = $urandom_range(0, 1);
      NZ_en    = $urandom_range(0, 1);
      C_en     = $urandom_range(0, 1);
      V_en     = $urandom_range(0, 1);
      BIT_en   = ($urandom_range(0, 5) == 0);
      DB       = 8'($urandom);
      PLD_en   = ($urandom_range(0, 6) == 0);
      RTI_en   = $urandom_range(0, 1);
      SC_op    = (($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0);
      INT_SEI  = ($urandom_range(0, 7) == 0);
      BRK_flag = $urandom_range(0, 1);
      BR_cond  = 3'($urandom_range(0, 7));
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Holds the 6502 processor status register (P) for the NES CPU core. Sits directly downstream of the ALU: it consumes the ALU's 8-bit result, carry-out and overflow-out and commits N/Z/C/V under per-flag update enables from the instruction decoder. It also handles flag loads from the data bus (PLP/RTI), explicit set/clear instructions, BIT, and the interrupt-entry I set. It provides the push image of P, branch-condition evaluation, and the one-instruction-delayed I mask used by the interrupt poller.

## Interface
Parameters:
- RESET_P, 8'h24, value of P after reset: I=1, bit 5=1, all others 0.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_n  in  1  synchronous, active-low reset.
- STEP_en  in  1  CPU cycle enable; no state changes when low.
- SYNC  in  1  high during an opcode-fetch cycle, which is the instruction boundary.
- RES  in  8  ALU result.
- Cout  in  1  ALU carry out.
- OVFout  in  1  ALU overflow out.
- NZ_en, C_en, V_en  in  1 each  commit N/Z, C or V from the ALU outputs.
- BIT_en  in  1  BIT update: N<=DB[7], V<=DB[6], Z<=(RES==0). RES carries A&M.
- DB  in  8  data bus, the source for flag loads and BIT.
- PLD_en  in  1  load P from DB, used by PLP and RTI.
- RTI_en  in  1  qualifies PLD_en as RTI, which changes the I-mask timing.
- SC_op  in  3  set/clear operation: 0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
- INT_SEI  in  1  set I on interrupt/BRK entry.
- BRK_flag  in  1  B value to place in the push image.
- BR_cond  in  3  branch selector, equal to opcode bits [7:5].
- P_q  out  8  current P as {N,V,1,0,D,I,Z,C}.
- P_push  out  8  push image {N,V,1,BRK_flag,D,I,Z,C}, combinational.
- BR_take  out  1  branch taken, combinational from P_q.
- I_mask  out  1  I as seen by the interrupt poller.

## Operation
- An update occurs only when STEP_en=1 and RST_n=1. With RST_n=0 on an edge, P_q<=RESET_P and I_mask<=1, regardless of STEP_en.
- Bit 5 always reads 1. Bit 4 of P_q always reads 0, because B exists only in P_push.
- Flag update rules:
  - NZ_en: N<=RES[7], Z<=(RES==8'h00).
  - C_en: C<=Cout.
  - V_en: V<=OVFout.
- Update priority per edge, highest first: PLD_en > INT_SEI > SC_op != 0 > BIT_en > ALU enables.
  - A higher-priority source owns every flag it writes.
  - Lower sources still update flags the higher source does not touch. Example: SC_op=SEC with NZ_en=1 sets C and updates N and Z.
- PLD_en: P_q <= {DB[7:6], 1, 0, DB[3:0]}. DB[5] and DB[4] are ignored.
- Branch evaluation:
  - BR_cond[2:1] selects the flag: 00 N, 01 V, 10 C, 11 Z.
  - BR_take = selected flag == BR_cond[0].
- I_mask rules:
  - On STEP_en & SYNC, I_mask <= P_q.I, using the value before this edge's update. This gives the 6502 one-instruction delay for CLI, SEI and PLP.
  - If PLD_en & RTI_en, I_mask <= DB[2] on the same edge, overriding SYNC sampling.
  - INT_SEI sets I_mask <= 1 immediately on the same edge.
- Undefined combinations have fixed outcomes:
  - SC_op with an invalid flag is not possible, since all 8 encodings are defined.
  - RTI_en without PLD_en is ignored.

## Timing
- Latency: all flag writes are visible on P_q one cycle after the enabling edge.
- BR_take and P_push follow P_q combinationally, with no added latency.
- I_mask lags P_q.I by up to one instruction, except for RTI and interrupt entry.
- Reset in mid-instruction discards any pending update on that edge.
- A STEP_en=0 stall holds every register, including I_mask, even if SYNC=1.

## Structure
- Shared package `cpu_pkg` contains:
  - SC_op encodings: SC_NONE, SC_CLC through SC_SED.
  - Flag bit indices: P_C=0, P_Z=1, P_I=2, P_D=3, P_B=4, P_U=5, P_V=6, P_N=7.
  - RESET_P default.
  - BR_cond field positions.
- One sub-module: `branch_cond`, the combinational BR_cond/P -> BR_take evaluator, which the branch-target adder also reuses.

## Test plan
- Reset: RST_n=0 for one edge with STEP_en=0 -> P_q=8'h24, I_mask=1, P_push with BRK_flag=1 = 8'h34.
- ALU commit: RES=8'h00, Cout=1, OVFout=1, NZ_en=C_en=V_en=1 -> P_q=8'h67. Then RES=8'h80 with NZ_en only -> P_q=8'hE5.
- PLP vs RTI:
  - DB=8'hFF, PLD_en=1 -> P_q=8'hEF. I_mask is still 0 (from a prior CLI); it becomes 1 only on the next SYNC edge.
  - The same load with RTI_en=1 -> I_mask=1 on the same edge.
- CLI delay: I=1, SC_op=CLI -> P_q.I=0 next cycle. I_mask stays 1 until the following STEP_en&SYNC edge, then goes to 0.
- Priority: PLD_en=1 with DB=8'h00, SC_op=SEC and NZ_en=1 at the same time -> P_q=8'h20.
- Branch: P_q=8'h21 (C=1) -> BR_cond=3'b101 (BCS) gives BR_take=1, BR_cond=3'b100 (BCC) gives 0. Repeat the check for all 8 encodings against each flag toggled.
